// File: rtl/msk_aes128_ct_collector.sv
// ---------------------------------------------------------------------------
// msk_aes128_ct_collector
//
// Receive end of a masked AES-128 core. The core has no backpressure. When the
// core raises its one-cycle result strobe, this block captures the masked
// ciphertext shares into a small share FIFO. Captured blocks are offered
// downstream over a valid/ready handshake. Launch credits keep the number of
// started-but-unreturned blocks plus the number of stored blocks within DEPTH,
// so every result has a reserved slot.
//
// Shares are only moved and never recombined. Two paths are driven to zero:
// the output bus while the FIFO is empty, and each slot at the edge where it
// is popped. Unmasked data therefore never lingers in the datapath.
//
// Ports
//   clk                 in   1      clock, rising edge
//   nrst                in   1      asynchronous active-low reset
//   core_launch         in   1      core accepted a block this cycle
//   core_cipher_valid   in   1      core result strobe (one cycle)
//   core_sh_ciphertext  in   128*d  masked ciphertext, sampled on the strobe
//   launch_allow        out  1      upstream may start the core this cycle
//   out_valid           out  1      FIFO head valid
//   out_ready           in   1      downstream accepts the head
//   out_sh_ciphertext   out  128*d  head entry, all-zero when out_valid=0
//   occupancy           out  CW     entries stored
//   inflight            out  CW     launches not yet returned
//   err_overflow        out  1      sticky: strobe with FIFO full and no pop
//   err_credit          out  1      sticky: launch without credit, or strobe
//                                   with nothing in flight
// ---------------------------------------------------------------------------
module msk_aes128_ct_collector #(
  parameter int d     = 2,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              core_launch,
  input  logic              core_cipher_valid,
  input  logic [128*d-1:0]  core_sh_ciphertext,
  output logic              launch_allow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [128*d-1:0]  out_sh_ciphertext,
  output logic [CW-1:0]     occupancy,
  output logic [CW-1:0]     inflight,
  output logic              err_overflow,
  output logic              err_credit
);

  localparam int W  = 128 * d;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inf_q, inf_d;
  logic          err_ov_q, err_ov_d;
  logic          err_cr_q, err_cr_d;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic allow;

  assign full  = (occ_q == DEPTH_C);
  assign empty = (occ_q == '0);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the head slot, so a strobe can land in a
  // full FIFO as long as downstream takes the head at that edge.
  assign push  = core_cipher_valid && (!full || pop);

  // Credit check from registered counters only. Same-cycle pops or strobes do
  // not widen the window. This keeps launch_allow free of any path from the
  // inputs.
  logic [CW:0] reserved;
  assign reserved = {1'b0, inf_q} + {1'b0, occ_q};
  assign allow    = (reserved < {1'b0, DEPTH_C});

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    inf_d    = inf_q;
    err_ov_d = err_ov_q;
    err_cr_d = err_cr_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    // In-flight count saturates at both ends. This keeps a misbehaving
    // upstream from wrapping it. A launch and a return in the same cycle
    // cancel out.
    unique case ({core_launch, core_cipher_valid})
      2'b10:   inf_d = (inf_q == DEPTH_C) ? inf_q : inf_q + CW'(1);
      2'b01:   inf_d = (inf_q == '0)      ? inf_q : inf_q - CW'(1);
      default: inf_d = inf_q;
    endcase

    if (core_cipher_valid && full && !pop) begin
      err_ov_d = 1'b1;
    end
    if ((core_launch && !allow) || (core_cipher_valid && (inf_q == '0))) begin
      err_cr_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, regardless of statement order.
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      inf_q    <= '0;
      err_ov_q <= 1'b0;
      err_cr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      inf_q    <= inf_d;
      err_ov_q <= err_ov_d;
      err_cr_q <= err_cr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Share storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array is reset on purpose. Masked shares must not
  // survive a reset. This forces flops rather than a RAM macro, which is
  // acceptable for a handful of entries.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // The zeroise is written before the capture. When the FIFO is full and
      // a push and a pop happen together, wr_ptr equals rd_ptr. The later
      // assignment wins, so the freed slot keeps the new ciphertext.
      if (pop) begin
        mem_q[rd_ptr_q] <= '0;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= core_sh_ciphertext;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all from registers)
  // -------------------------------------------------------------------------
  assign out_valid         = !empty;
  assign out_sh_ciphertext = out_valid ? mem_q[rd_ptr_q] : '0;
  assign launch_allow      = allow;
  assign occupancy         = occ_q;
  assign inflight          = inf_q;
  assign err_overflow      = err_ov_q;
  assign err_credit        = err_cr_q;

endmodule

// File: tb/tb_msk_aes128_ct_collector.sv
// ---------------------------------------------------------------------------
// Directed bench for msk_aes128_ct_collector, configured with d=2 and DEPTH=2.
// A table of per-cycle records drives the main sequence. Each record holds
// the inputs applied for one clock and the outputs expected after that edge.
// Hand-written sequences cover reset mid-burst and the credit-error corners.
// ---------------------------------------------------------------------------
module tb_msk_aes128_ct_collector;

  localparam int D     = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = 128 * D;

  logic          clk;
  logic          nrst;
  logic          core_launch;
  logic          core_cipher_valid;
  logic [W-1:0]  core_sh_ciphertext;
  logic          launch_allow;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sh_ciphertext;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic          err_overflow;
  logic          err_credit;

  msk_aes128_ct_collector #(.d(D), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .core_launch        (core_launch),
    .core_cipher_valid  (core_cipher_valid),
    .core_sh_ciphertext (core_sh_ciphertext),
    .launch_allow       (launch_allow),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_sh_ciphertext  (out_sh_ciphertext),
    .occupancy          (occupancy),
    .inflight           (inflight),
    .err_overflow       (err_overflow),
    .err_credit         (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Distinct share patterns per block.
  localparam logic [W-1:0] S0 = {8{32'hA5A5_0000}};
  localparam logic [W-1:0] S1 = {8{32'h5A5A_1111}};
  localparam logic [W-1:0] S2 = {8{32'hC3C3_2222}};
  localparam logic [W-1:0] S3 = {8{32'h3C3C_3333}};
  localparam logic [W-1:0] Z  = '0;

  typedef struct {
    logic          launch;
    logic          strobe;
    logic [W-1:0]  din;
    logic          ready;
    logic          e_valid;
    logic [W-1:0]  e_data;
    logic [CW-1:0] e_occ;
    logic [CW-1:0] e_inf;
    logic          e_allow;
    logic          e_ov;
    logic          e_cr;
  } vec_t;

  function automatic vec_t mk(input logic l, input logic s, input logic [W-1:0] din,
                              input logic r, input logic v, input logic [W-1:0] dat,
                              input int occ, input int inf, input logic al,
                              input logic ov, input logic cr);
    vec_t t;
    t.launch = l;  t.strobe = s;  t.din = din;  t.ready = r;
    t.e_valid = v; t.e_data = dat;
    t.e_occ = CW'(occ); t.e_inf = CW'(inf);
    t.e_allow = al; t.e_ov = ov; t.e_cr = cr;
    return t;
  endfunction

  // Apply inputs at a falling edge and run through one rising edge. The
  // routine returns at the next falling edge, away from the active edge.
  task automatic step(input logic l, input logic s, input logic [W-1:0] din, input logic r);
    core_launch        = l;
    core_cipher_valid  = s;
    core_sh_ciphertext = din;
    out_ready          = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [W-1:0] dat,
                           input int occ, input int inf, input logic al,
                           input logic ov, input logic cr);
    check({tag, ".valid"}, W'(out_valid),         W'(v));
    check({tag, ".data"},  out_sh_ciphertext,     dat);
    check({tag, ".occ"},   W'(occupancy),         W'(occ));
    check({tag, ".inf"},   W'(inflight),          W'(inf));
    check({tag, ".allow"}, W'(launch_allow),      W'(al));
    check({tag, ".ov"},    W'(err_overflow),      W'(ov));
    check({tag, ".cr"},    W'(err_credit),        W'(cr));
  endtask

  // Pulse reset asynchronously between edges. Outputs are checked while nrst
  // is still low, and the release happens on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 nrst = 1'b0;
    core_launch = 1'b0; core_cipher_valid = 1'b0; out_ready = 1'b0;
    core_sh_ciphertext = '0;
    #1 check_all(tag, 1'b0, Z, 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  vec_t vecs[20];

  initial begin
    nrst = 1'b0;
    core_launch = 1'b0; core_cipher_valid = 1'b0; out_ready = 1'b0;
    core_sh_ciphertext = '0;

    //                l  s  din ry  v  data occ inf al ov cr
    vecs[0]  = mk(1, 0, Z,  0,  0, Z,  0, 1, 1, 0, 0); // launch
    vecs[1]  = mk(0, 1, S0, 0,  1, S0, 1, 0, 1, 0, 0); // strobe -> visible next cycle
    vecs[2]  = mk(0, 0, Z,  1,  0, Z,  0, 0, 1, 0, 0); // pop -> bus zero
    vecs[3]  = mk(1, 0, Z,  0,  0, Z,  0, 1, 1, 0, 0);
    vecs[4]  = mk(1, 0, Z,  0,  0, Z,  0, 2, 0, 0, 0); // credits exhausted
    vecs[5]  = mk(0, 1, S0, 0,  1, S0, 1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1, S1, 0,  1, S0, 2, 0, 0, 0, 0); // full
    vecs[7]  = mk(0, 0, Z,  1,  1, S1, 1, 0, 1, 0, 0); // pop S0 -> allow back
    vecs[8]  = mk(1, 0, Z,  0,  1, S1, 1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1, S2, 0,  1, S1, 2, 0, 0, 0, 0); // full: S1,S2
    vecs[10] = mk(0, 1, S3, 1,  1, S2, 2, 0, 0, 0, 1); // full push+pop, no overflow
    vecs[11] = mk(0, 0, Z,  1,  1, S3, 1, 0, 1, 0, 1);
    vecs[12] = mk(0, 1, S0, 0,  1, S3, 2, 0, 0, 0, 1);
    vecs[13] = mk(0, 1, S1, 0,  1, S3, 2, 0, 0, 1, 1); // overflow, S1 dropped
    vecs[14] = mk(0, 0, Z,  0,  1, S3, 2, 0, 0, 1, 1); // sticky
    vecs[15] = mk(0, 0, Z,  1,  1, S0, 1, 0, 1, 1, 1); // contents intact
    vecs[16] = mk(0, 0, Z,  1,  0, Z,  0, 0, 1, 1, 1);
    vecs[17] = mk(1, 1, S2, 0,  1, S2, 1, 0, 1, 1, 1); // launch+strobe: inflight same
    vecs[18] = mk(0, 1, S1, 1,  1, S1, 1, 0, 1, 1, 1); // push+pop at occupancy 1
    vecs[19] = mk(0, 0, Z,  1,  0, Z,  0, 0, 1, 1, 1);

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, Z, 0, 0, 1'b1, 1'b0, 1'b0);
    nrst = 1'b1;

    // Main table
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].launch, vecs[i].strobe, vecs[i].din, vecs[i].ready);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                int'(vecs[i].e_occ), int'(vecs[i].e_inf), vecs[i].e_allow,
                vecs[i].e_ov, vecs[i].e_cr);
    end

    // Reset mid-burst with two entries held and one block in flight
    do_reset("rst0");
    step(1, 0, Z,  0);
    step(1, 0, Z,  0);
    step(0, 1, S0, 0);
    step(0, 1, S1, 0);
    check_all("burst", 1'b1, S0, 2, 0, 1'b0, 1'b0, 1'b0);
    do_reset("rst_mid");
    check_all("post_rst", 1'b0, Z, 0, 0, 1'b1, 1'b0, 1'b0);

    // Launch while out of credit: counted, saturating, credit error raised
    step(1, 0, Z, 0);
    step(1, 0, Z, 0);
    check_all("cr_full", 1'b0, Z, 0, 2, 1'b0, 1'b0, 1'b0);
    step(1, 0, Z, 0);
    check_all("cr_launch", 1'b0, Z, 0, 2, 1'b0, 1'b0, 1'b1);

    // Strobe with nothing in flight: stored anyway, credit error raised
    do_reset("rst1");
    step(0, 1, S3, 0);
    check_all("cr_strobe", 1'b1, S3, 1, 0, 1'b1, 1'b0, 1'b1);
    step(0, 0, Z, 1);
    check_all("cr_pop", 1'b0, Z, 0, 0, 1'b1, 1'b0, 1'b1);
    check("slot0_zeroised", dut.mem_q[0], Z);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
